// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding, owner IDs and default
// block size.
package mem_arb_pkg;

   localparam int unsigned BeatsDefault = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDWr   = 2'd1,
      StDFill = 2'd2,
      StIFill = 2'd3
   } arb_state_e;

   typedef enum logic {
      OwnerD = 1'b0,
      OwnerI = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arb_beat_cnt.sv
// Counts returned memory beats during a block fill and flags the final beat; wraps to zero
// only on that final beat.
module mem_arb_beat_cnt
   import mem_arb_pkg::*;
#(
   parameter int unsigned BEATS = BeatsDefault
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic beat_i,
   output logic last_o
);

   localparam int unsigned CntW = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign last_o = beat_i && (cnt_q == CntW'(BEATS - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (last_o) begin
         cnt_d = '0;
      end else if (beat_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single unified memory between the I-cache and D-cache fill FSMs.
// Build option: define MEM_ARB_RR_EN for round-robin between competing fills.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned BEATS  = BeatsDefault
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_rd,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_grant,
   output logic              i_data_valid,
   input  logic              d_req_rd,
   input  logic              d_req_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_grant,
   output logic              d_data_valid,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e state_q, state_d;
   logic       fill_beat;
   logic       last_beat;
   logic       pick_i;

   // Read data goes straight to both caches; only data_valid is steered.
   logic [DATA_W-1:0] unused_rdata;
   assign unused_rdata = mem_rdata;

   assign fill_beat = mem_valid && ((state_q == StDFill) || (state_q == StIFill));

   mem_arb_beat_cnt #(
      .BEATS (BEATS)
   ) u_beat_cnt (
      .clk_i  (clk),
      .rst_ni (rst),
      .beat_i (fill_beat),
      .last_o (last_beat)
   );

`ifdef MEM_ARB_RR_EN
   owner_e rr_q, rr_d;

   // rr_q names the fill owner favoured on the next contended pick.
   assign pick_i = i_req_rd && (!d_req_rd || (rr_q == OwnerI));

   always_comb begin
      rr_d = rr_q;
      if (state_q == StIdle) begin
         if (state_d == StDFill) begin
            rr_d = OwnerI;
         end else if (state_d == StIFill) begin
            rr_d = OwnerD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_q <= OwnerD;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   assign pick_i = i_req_rd && !d_req_rd;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (d_req_wr) begin
               state_d = StDWr;
            end else if (pick_i) begin
               state_d = StIFill;
            end else if (d_req_rd) begin
               state_d = StDFill;
            end
         end
         StDWr: begin
            state_d = StIdle;
         end
         StDFill, StIFill: begin
            // Grant is held until the last beat even if the owner drops its request.
            if (last_beat) begin
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      i_grant      = 1'b0;
      i_data_valid = 1'b0;
      d_grant      = 1'b0;
      d_data_valid = 1'b0;
      mem_enable   = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      unique case (state_q)
         StIdle: begin
         end
         StDWr: begin
            d_grant    = 1'b1;
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = d_addr;
         end
         StDFill: begin
            d_grant      = 1'b1;
            mem_enable   = d_req_rd;
            mem_addr     = d_addr;
            d_data_valid = mem_valid;
         end
         StIFill: begin
            i_grant      = 1'b1;
            mem_enable   = i_req_rd;
            mem_addr     = i_addr;
            i_data_valid = mem_valid;
         end
      endcase
   end

   // Write data follows the D-cache, but is forced low while reset is held.
   assign mem_wdata = rst ? d_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter, checked against a transaction-level model
// (owner + beats remaining). Honours MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int NB = 8;
`ifdef MEM_ARB_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_req_rd, d_req_rd, d_req_wr, mem_valid;
   logic [AW-1:0] i_addr, d_addr, mem_addr;
   logic [DW-1:0] d_wdata, mem_wdata, mem_rdata;
   logic          i_grant, i_data_valid, d_grant, d_data_valid, mem_enable, mem_wr;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Model: 0 idle, 1 write-through, 2 D fill, 3 I fill.
   int m_mode = 0;
   int m_left = NB;
   bit m_pref_i = 1'b0;
   int dv_i_seen = 0;
   int dv_d_seen = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req_rd     (i_req_rd),
      .i_addr       (i_addr),
      .i_grant      (i_grant),
      .i_data_valid (i_data_valid),
      .d_req_rd     (d_req_rd),
      .d_req_wr     (d_req_wr),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_grant      (d_grant),
      .d_data_valid (d_data_valid),
      .mem_enable   (mem_enable),
      .mem_wr       (mem_wr),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_valid    (mem_valid),
      .mem_rdata    (mem_rdata)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] obs_flags();
      return {i_grant, i_data_valid, d_grant, d_data_valid, mem_enable, mem_wr};
   endfunction

   function automatic logic [5:0] exp_flags();
      logic [5:0] e;
      e[5] = (m_mode == 3);
      e[4] = (m_mode == 3) && mem_valid;
      e[3] = (m_mode == 1) || (m_mode == 2);
      e[2] = (m_mode == 2) && mem_valid;
      e[1] = (m_mode == 1) || ((m_mode == 2) && d_req_rd) || ((m_mode == 3) && i_req_rd);
      e[0] = (m_mode == 1);
      return e;
   endfunction

   function automatic logic [AW-1:0] exp_addr();
      if (m_mode == 1 || m_mode == 2) return d_addr;
      if (m_mode == 3) return i_addr;
      return '0;
   endfunction

   task automatic clear_inputs();
      i_req_rd = 1'b0; d_req_rd = 1'b0; d_req_wr = 1'b0; mem_valid = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
   endtask

   task automatic model_reset();
      m_mode = 0; m_left = NB; m_pref_i = 1'b0;
   endtask

   // Check outputs mid-cycle, then advance the model across the next rising edge.
   task automatic tick();
      int nm, nl;
      bit np;
      @(negedge clk);
      check_eq("flags", {58'd0, obs_flags()}, {58'd0, exp_flags()});
      check_eq("mem_addr", mem_addr, exp_addr());
      check_eq("mem_wdata", mem_wdata, d_wdata);
      if (i_data_valid) dv_i_seen++;
      if (d_data_valid) dv_d_seen++;
      nm = m_mode; nl = m_left; np = m_pref_i;
      case (m_mode)
         0: begin
            if (d_req_wr) nm = 1;
            else if (d_req_rd && i_req_rd) nm = (RrEn && m_pref_i) ? 3 : 2;
            else if (d_req_rd) nm = 2;
            else if (i_req_rd) nm = 3;
            if (nm == 2) np = 1'b1;
            if (nm == 3) np = 1'b0;
            nl = NB;
         end
         1: nm = 0;
         default: begin
            if (mem_valid) begin
               nl--;
               if (nl == 0) nm = 0;
            end
         end
      endcase
      @(posedge clk);
      #1;
      m_mode = nm; m_left = nl; m_pref_i = np;
   endtask

   task automatic run_beats(input int n);
      for (int k = 0; k < n; k++) begin
         mem_valid = 1'b1;
         tick();
      end
      mem_valid = 1'b0;
   endtask

   initial begin
      int base;
      logic [2:0] order;
      clear_inputs();
      model_reset();
      #1;
      check_eq("reset_outputs", {obs_flags(), mem_addr, mem_wdata}, '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // 1) lone I fill
      i_req_rd = 1'b1; i_addr = 16'h1230;
      tick();
      check_eq("t1_i_grant", i_grant, 1'b1);
      base = dv_i_seen;
      run_beats(NB);
      check_eq("t1_i_beats", dv_i_seen - base, NB);
      check_eq("t1_i_grant_drop", i_grant, 1'b0);
      i_req_rd = 1'b0;
      tick();

      // 2) write-through
      d_req_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
      tick();
      check_eq("t2_write", {obs_flags(), mem_addr, mem_wdata}, {6'b001011, 16'h0040, 16'hBEEF});
      d_req_wr = 1'b0;
      tick();
      check_eq("t2_d_grant_drop", d_grant, 1'b0);

      // 3) contended fills: D first, then I
      d_req_rd = 1'b1; i_req_rd = 1'b1; d_addr = 16'h0200; i_addr = 16'h0300;
      tick();
      check_eq("t3_d_first", {i_grant, d_grant}, 2'b01);
      base = dv_d_seen;
      run_beats(NB);
      check_eq("t3_d_beats", dv_d_seen - base, NB);
      d_req_rd = 1'b0;
      tick();
      check_eq("t3_i_second", {i_grant, d_grant}, 2'b10);
      run_beats(NB);
      i_req_rd = 1'b0;
      tick();

`ifdef MEM_ARB_RR_EN
      // 4) round-robin alternation under persistent contention
      d_req_rd = 1'b1; i_req_rd = 1'b1;
      for (int r = 0; r < 3; r++) begin
         tick();
         order[r] = i_grant;
         run_beats(NB);
      end
      check_eq("t4_rr_order", order, 3'b010);
      d_req_rd = 1'b0; i_req_rd = 1'b0;
      tick();
`endif

      // 5) write arriving mid I fill waits for the fill
      i_req_rd = 1'b1; i_addr = 16'h0500;
      tick();
      base = dv_i_seen;
      run_beats(2);
      d_req_wr = 1'b1; d_addr = 16'h0600; d_wdata = 16'h1234;
      run_beats(NB - 2);
      check_eq("t5_i_beats", dv_i_seen - base, NB);
      check_eq("t5_idle_gap", {i_grant, d_grant}, 2'b00);
      i_req_rd = 1'b0;
      tick();
      check_eq("t5_d_write", {d_grant, mem_wr, mem_addr}, {2'b11, 16'h0600});
      d_req_wr = 1'b0;
      tick();

      // 6) reset during a D fill
      d_req_rd = 1'b1; d_addr = 16'h0700; d_wdata = 16'h5A5A;
      tick();
      run_beats(4);
      mem_valid = 1'b1;
      rst = 1'b0;
      #1;
      check_eq("t6_reset_outputs", {obs_flags(), mem_addr, mem_wdata}, '0);
      model_reset();
      #2;
      rst = 1'b1;
      d_req_rd = 1'b0;
      base = dv_d_seen + dv_i_seen;
      for (int k = 0; k < 3; k++) tick();
      mem_valid = 1'b0;
      check_eq("t6_stray_valid", dv_d_seen + dv_i_seen - base, 0);

      // Random traffic against the model
      for (int c = 0; c < 2000; c++) begin
         i_req_rd  = ($urandom_range(0, 9) < 4);
         d_req_rd  = ($urandom_range(0, 9) < 3);
         d_req_wr  = ($urandom_range(0, 9) < 2);
         mem_valid = ($urandom_range(0, 9) < 6);
         i_addr    = AW'($urandom);
         d_addr    = AW'($urandom);
         d_wdata   = DW'($urandom);
         mem_rdata = DW'($urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
